// File: rtl/mem_stage.sv
// -----------------------------------------------------------------------------
// mem_stage
//   Memory stage between execute and writeback. Issues word loads and stores on
//   a req/gnt/rvalid data-memory port, stalls upstream while an access is in
//   flight, and registers the result into the mem->wb pipeline register.
//
// Parameters
//   TIMEOUT_CYC   cycles allowed in REQ or RESP before the access is aborted
//                 (1..255)
//
// Ports
//   clk, rst                       clock, synchronous active-high reset
//   ex_mem_write / ex_mem_read     memory operation from execute
//   ex_reg_write, ex_rd            writeback enable / destination from execute
//   ex_alu_result, ex_mem_data     address (or ALU result) / store data
//   stall                          hold execute/decode/fetch this cycle
//   bp_mem                         forwarding value for the MEM bypass
//   dmem_req/we/addr/wdata         data-memory request
//   dmem_gnt, dmem_rvalid, rdata   data-memory handshake and load data
//   wb_reg_write, wb_rd, wb_result mem->wb pipeline register
//   mem_err                        one-cycle pulse: misaligned access or timeout
// -----------------------------------------------------------------------------
module mem_stage #(
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_mem_write,
    input  logic        ex_mem_read,
    input  logic        ex_reg_write,
    input  logic [4:0]  ex_rd,
    input  logic [31:0] ex_alu_result,
    input  logic [31:0] ex_mem_data,
    output logic        stall,
    output logic [31:0] bp_mem,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_gnt,
    input  logic        dmem_rvalid,
    input  logic [31:0] dmem_rdata,
    output logic        wb_reg_write,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_result,
    output logic        mem_err
);

    typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

    // Last count value before the wait budget is exhausted.
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYC - 1);

    state_t      state_reg, state_next;
    logic [7:0]  cnt_reg, cnt_next;
    logic        wb_reg_write_reg;
    logic [4:0]  wb_rd_reg;
    logic [31:0] wb_result_reg;
    logic        mem_err_reg;

    logic mem_op;
    logic misaligned;
    logic is_store;
    logic req_int;
    logic done;
    logic abort;
    logic busy;

    assign mem_op     = ex_mem_read | ex_mem_write;
    assign misaligned = mem_op & (ex_alu_result[1:0] != 2'b00);
    assign is_store   = ex_mem_write;

    // Address, direction and data are pure pass-through; upstream holds ex_*
    // stable during a stall, which keeps them stable across REQ.
    assign bp_mem     = ex_alu_result;
    assign dmem_addr  = ex_alu_result;
    assign dmem_wdata = ex_mem_data;
    assign dmem_we    = ex_mem_write;

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        req_int    = 1'b0;
        done       = 1'b0;
        abort      = 1'b0;
        case (state_reg)
            IDLE: begin
                req_int = mem_op & ~misaligned;
                if (req_int) begin
                    cnt_next = 8'd0;
                    if (dmem_gnt) begin
                        if (is_store) done = 1'b1;
                        else          state_next = RESP;
                    end else begin
                        state_next = REQ;
                    end
                end
            end
            REQ: begin
                req_int = 1'b1;
                if (dmem_gnt) begin
                    cnt_next = 8'd0;
                    if (is_store) begin
                        done       = 1'b1;
                        state_next = IDLE;
                    end else begin
                        state_next = RESP;
                    end
                end else if (cnt_reg == CNT_LAST) begin
                    abort      = 1'b1;
                    state_next = IDLE;
                end else begin
                    cnt_next = cnt_reg + 8'd1;
                end
            end
            RESP: begin
                // A response on the final allowed cycle still wins over the abort.
                if (dmem_rvalid) begin
                    done       = 1'b1;
                    state_next = IDLE;
                end else if (cnt_reg == CNT_LAST) begin
                    abort      = 1'b1;
                    state_next = IDLE;
                end else begin
                    cnt_next = cnt_reg + 8'd1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign busy     = (state_reg != IDLE) | (mem_op & ~misaligned);
    // Gated by rst so the combinational outputs are already quiet in the reset cycle.
    assign stall    = ~rst & busy & ~done & ~abort;
    assign dmem_req = ~rst & req_int;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg        <= IDLE;
            cnt_reg          <= 8'd0;
            wb_reg_write_reg <= 1'b0;
            wb_rd_reg        <= 5'd0;
            wb_result_reg    <= 32'd0;
            mem_err_reg      <= 1'b0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            mem_err_reg <= ((state_reg == IDLE) & misaligned) | abort;
            if (!stall && (state_reg == IDLE) && !mem_op) begin
                wb_reg_write_reg <= ex_reg_write & (ex_rd != 5'd0);
                wb_rd_reg        <= ex_rd;
                wb_result_reg    <= ex_alu_result;
            end else if (done && !is_store) begin
                wb_reg_write_reg <= ex_reg_write & (ex_rd != 5'd0);
                wb_rd_reg        <= ex_rd;
                wb_result_reg    <= dmem_rdata;
            end else begin
                // Bubble: stall, store completion, misalignment or timeout.
                wb_reg_write_reg <= 1'b0;
            end
        end
    end

    assign wb_reg_write = wb_reg_write_reg;
    assign wb_rd        = wb_rd_reg;
    assign wb_result    = wb_result_reg;
    assign mem_err      = mem_err_reg;

endmodule
